// File: rtl/dino_pkg.sv
// dino_pkg: shared state encoding and datapath widths for the dino game (scroll_ctrl, Ground)
package dino_pkg;
  localparam int SPEED_W = 4;
  localparam int POS_W = 6;
  localparam int SCORE_W = 14;
`ifdef SCROLL_PAUSE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OVER, ST_PAUSE} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OVER} state_e;
`endif
endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: registered rising-edge detector on fresh; ports clk, rst, fresh -> frame_tick (one-cycle pulse)
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic fresh,
  output logic frame_tick
);
  logic fresh_q, tick_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      fresh_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      fresh_q <= fresh;
      tick_q <= fresh & ~fresh_q;
    end
  end
  assign frame_tick = tick_q;
endmodule

// File: rtl/scroll_ctrl.sv
// scroll_ctrl: dino game FSM plus per-frame scroll/speed/score; ports clk, rst, fresh, start_btn, collision -> game_status, game_over, speed, ground_position, score, frame_tick; SCROLL_PAUSE_EN adds a PAUSE state
module scroll_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned INIT_SPEED = 1,
  parameter int unsigned MAX_SPEED = 15,
  parameter int unsigned STEP_FRAMES = 256,
  parameter int unsigned SCORE_MAX = 9999
) (
  input  logic clk,
  input  logic rst,
  input  logic fresh,
  input  logic start_btn,
  input  logic collision,
  output logic game_status,
  output logic game_over,
  output logic [SPEED_W-1:0] speed,
  output logic [POS_W-1:0] ground_position,
  output logic [SCORE_W-1:0] score,
  output logic frame_tick
);
  localparam int CNT_W = STEP_FRAMES > 1 ? $clog2(STEP_FRAMES) : 1;
  state_e state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic armed_q, armed_d;
  logic load, step_end;
  frame_tick_gen u_tick (
    .clk(clk),
    .rst(rst),
    .fresh(fresh),
    .frame_tick(frame_tick)
  );
`ifdef SCROLL_PAUSE_EN
  logic start_q, start_rise;
  always_ff @(posedge clk) start_q <= rst ? 1'b0 : start_btn;
  assign start_rise = start_btn & ~start_q;
`endif
  assign step_end = cnt_q == CNT_W'(STEP_FRAMES - 1);
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    speed_d = speed_q;
    pos_d = pos_q;
    score_d = score_q;
    cnt_d = cnt_q;
    load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load = start_btn;
        state_d = start_btn ? ST_RUN : ST_IDLE;
      end
      ST_RUN:
        if (collision) begin
          state_d = ST_OVER;
          armed_d = 1'b0;
        end
`ifdef SCROLL_PAUSE_EN
        else if (start_rise) state_d = ST_PAUSE;
`endif
        else if (frame_tick) begin
          // position advances by the speed in force before this frame's ramp
          pos_d = pos_q + POS_W'(speed_q);
          score_d = score_q == SCORE_W'(SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
          cnt_d = step_end ? '0 : cnt_q + CNT_W'(1);
          speed_d = step_end && speed_q != SPEED_W'(MAX_SPEED) ? speed_q + SPEED_W'(1) : speed_q;
        end
      ST_OVER: begin
        // restart needs a released button first so a held press cannot auto-restart
        load = armed_q & start_btn;
        state_d = load ? ST_RUN : ST_OVER;
        armed_d = armed_q | ~start_btn;
      end
`ifdef SCROLL_PAUSE_EN
      ST_PAUSE: state_d = start_rise ? ST_RUN : ST_PAUSE;
`endif
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      speed_d = SPEED_W'(INIT_SPEED);
      pos_d = '0;
      score_d = '0;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
      speed_q <= '0;
      pos_q <= '0;
      score_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      speed_q <= speed_d;
      pos_q <= pos_d;
      score_q <= score_d;
      cnt_q <= cnt_d;
    end
  end
  assign game_status = state_q == ST_RUN;
  assign game_over = state_q == ST_OVER;
  assign speed = speed_q;
  assign ground_position = pos_q;
  assign score = score_q;
endmodule

// File: tb/tb_scroll_ctrl.sv
// tb_scroll_ctrl: directed stimulus on two scroll_ctrl configurations checked each cycle against a frame-count model
module tb_scroll_ctrl;
  logic clk = 1'b0, rst = 1'b1, fresh = 1'b0, start_btn = 1'b0, collision = 1'b0;
  logic a_st, a_ov, a_tk, b_st, b_ov, b_tk;
  logic [3:0] a_sp, b_sp;
  logic [5:0] a_ps, b_ps;
  logic [13:0] a_sc, b_sc;
  int pass = 0, total = 0, ticks;
  bit live = 0;
  always #5 clk = ~clk;
  scroll_ctrl dut_a (
    .clk(clk), .rst(rst), .fresh(fresh), .start_btn(start_btn), .collision(collision),
    .game_status(a_st), .game_over(a_ov), .speed(a_sp), .ground_position(a_ps), .score(a_sc), .frame_tick(a_tk)
  );
  scroll_ctrl #(.INIT_SPEED(1), .MAX_SPEED(3), .STEP_FRAMES(4), .SCORE_MAX(25)) dut_b (
    .clk(clk), .rst(rst), .fresh(fresh), .start_btn(start_btn), .collision(collision),
    .game_status(b_st), .game_over(b_ov), .speed(b_sp), .ground_position(b_ps), .score(b_sc), .frame_tick(b_tk)
  );
  // mode: 0 idle, 1 run, 2 over, 3 pause; n = frames survived since last start
  typedef struct { int mode; bit armed; int n; int pos; bit fq; bit tk; bit sq; } mdl_t;
  mdl_t ma, mb;
  function automatic int spd(int n, int init, int mx, int stp);
    return (init + n / stp > mx) ? mx : init + n / stp;
  endfunction
  function automatic mdl_t step(mdl_t s, int init, int mx, int stp);
    mdl_t r = s;
    bit rise = start_btn & ~s.sq;
    if (rst) return '{0, 0, 0, 0, 0, 0, 0};
    r.tk = fresh & ~s.fq;
    r.fq = fresh;
    r.sq = start_btn;
    case (s.mode)
      0: if (start_btn) begin r.mode = 1; r.n = 0; r.pos = 0; end
      1: begin
        if (collision) begin r.mode = 2; r.armed = 0; end
`ifdef SCROLL_PAUSE_EN
        else if (rise) r.mode = 3;
`endif
        else if (s.tk) begin r.pos = (s.pos + spd(s.n, init, mx, stp)) % 64; r.n = s.n + 1; end
      end
      2: if (s.armed && start_btn) begin r.mode = 1; r.n = 0; r.pos = 0; end else if (!start_btn) r.armed = 1;
      3: if (rise) r.mode = 1;
      default: r.mode = 0;
    endcase
    return r;
  endfunction
  always @(posedge clk) begin
    ma = step(ma, 1, 15, 256);
    mb = step(mb, 1, 3, 4);
    if (rst) live = 1;
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  task automatic cmp(string p, mdl_t m, int init, int mx, int stp, int smax,
                     logic st, logic ov, logic [3:0] sp, logic [5:0] ps, logic [13:0] sc, logic tk);
    chk({p, "_status"}, 32'(st), 32'(m.mode == 1));
    chk({p, "_over"}, 32'(ov), 32'(m.mode == 2));
    chk({p, "_speed"}, 32'(sp), m.mode == 0 ? 0 : spd(m.n, init, mx, stp));
    chk({p, "_pos"}, 32'(ps), m.pos);
    chk({p, "_score"}, 32'(sc), m.n > smax ? smax : m.n);
    chk({p, "_tick"}, 32'(tk), 32'(m.tk));
  endtask
  always @(negedge clk) if (live) begin
    cmp("a", ma, 1, 15, 256, 9999, a_st, a_ov, a_sp, a_ps, a_sc, a_tk);
    cmp("b", mb, 1, 3, 4, 25, b_st, b_ov, b_sp, b_ps, b_sc, b_tk);
  end
  task automatic cyc(int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic frames(int k);
    repeat (k) begin
      fresh = 1'b1; cyc(3);
      fresh = 1'b0; cyc(3);
    end
  endtask
  task automatic press;
    start_btn = 1'b1; cyc(1);
    start_btn = 1'b0; cyc(1);
  endtask
  initial begin
    cyc(2);
    rst = 1'b0;
    frames(10);
    chk("idle_status", 32'(a_st), 0);
    chk("idle_speed", 32'(a_sp), 0);
    chk("idle_pos", 32'(a_ps), 0);
    chk("idle_score", 32'(a_sc), 0);
    press;
    chk("start_speed", 32'(a_sp), 1);
    chk("start_status", 32'(a_st), 1);
    frames(20);
    chk("a_pos20", 32'(a_ps), 20);
    chk("b_pos20", 32'(b_ps), 48);
    chk("b_speed20", 32'(b_sp), 3);
    frames(50);
    chk("a_pos70", 32'(a_ps), 6);
    chk("a_score70", 32'(a_sc), 70);
    chk("a_speed70", 32'(a_sp), 1);
    chk("b_pos70", 32'(b_ps), 6);
    chk("b_score_sat", 32'(b_sc), 25);
    fresh = 1'b1; cyc(1);
    chk("tick_at_collision", 32'(a_tk), 1);
    collision = 1'b1; start_btn = 1'b1; cyc(1);
    collision = 1'b0; fresh = 1'b0;
    chk("over_flag", 32'(a_ov), 1);
    chk("over_pos", 32'(a_ps), 6);
    chk("over_score", 32'(a_sc), 70);
    cyc(5);
    chk("held_stays_over", 32'(a_ov), 1);
    start_btn = 1'b0; cyc(1);
    start_btn = 1'b1; cyc(1);
    chk("restart_status", 32'(a_st), 1);
    chk("restart_score", 32'(a_sc), 0);
    chk("restart_speed", 32'(b_sp), 1);
    start_btn = 1'b0; cyc(1);
    fresh = 1'b1;
    ticks = 0;
    repeat (100) begin
      cyc(1);
      ticks += int'(a_tk);
    end
    fresh = 1'b0;
    chk("one_tick_per_edge", ticks, 1);
    cyc(2);
    chk("pos_after_long_fresh", 32'(a_ps), 1);
    rst = 1'b1; cyc(1);
    rst = 1'b0;
    chk("rst_status", 32'(a_st), 0);
    chk("rst_speed", 32'(a_sp), 0);
    chk("rst_pos", 32'(a_ps), 0);
    chk("rst_score", 32'(a_sc), 0);
    press;
    frames(3);
    press;
    frames(5);
`ifdef SCROLL_PAUSE_EN
    chk("pause_frozen_pos", 32'(a_ps), 3);
    chk("pause_status", 32'(a_st), 0);
`else
    chk("press_ignored_pos", 32'(a_ps), 8);
    chk("press_ignored_status", 32'(a_st), 1);
`endif
    press;
    frames(1);
`ifdef SCROLL_PAUSE_EN
    chk("resume_pos", 32'(a_ps), 4);
    chk("resume_score", 32'(a_sc), 4);
`else
    chk("run_pos", 32'(a_ps), 9);
    chk("run_score", 32'(a_sc), 9);
`endif
    cyc(2);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/scroll_ctrl.md
# scroll_ctrl

Frame-level controller for the dinosaur game's scrolling ground. Runs the game state machine (idle / running / over), turns the VGA `fresh` frame strobe into single-cycle frame ticks, and on each tick advances the ground scroll position, ramps scroll speed and counts score. Sits between the input/collision logic and the `Ground` renderer, which consumes `game_status`, `speed` and `ground_position`.

## Interface
- `INIT_SPEED`, 1, speed loaded on start/restart (1..MAX_SPEED)
- `MAX_SPEED`, 15, speed saturation value (≤15, fits 4 bits)
- `STEP_FRAMES`, 256, running frames between speed increments (≥1)
- `SCORE_MAX`, 9999, score saturation value

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `fresh`  in  1  frame strobe from VGA timing, level signal; rising edge = new frame
- `start_btn`  in  1  debounced start/restart request, level
- `collision`  in  1  dinosaur/obstacle overlap flag, level
- `game_status`  out  1  1 = running, 0 = idle or over
- `game_over`  out  1  1 while in OVER
- `speed`  out  4  current scroll speed, pixels per frame
- `ground_position`  out  6  scroll offset, modulo 64
- `score`  out  14  frames survived, saturating
- `frame_tick`  out  1  one-cycle pulse per `fresh` rising edge

## Operation
- States: IDLE, RUN, OVER (plus PAUSE when configured).
- IDLE: outputs hold reset values. `start_btn`=1 → RUN; load `speed`=INIT_SPEED, `ground_position`=0, `score`=0, frame counter=0.
- RUN, on `frame_tick` with `collision`=0: `ground_position` ← (`ground_position` + `speed`) mod 64 (6-bit wrap, carry discarded); `score` ← min(`score`+1, SCORE_MAX); frame counter +1; when counter reaches STEP_FRAMES−1 it clears and `speed` ← min(`speed`+1, MAX_SPEED). Position update uses the pre-increment speed.
- RUN, `collision`=1 (any cycle, tick or not) → OVER; no advance that cycle. Collision has priority over a simultaneous tick.
- OVER: `game_status`=0, `game_over`=1, speed/position/score frozen. `start_btn` must be seen 0 at least one cycle after entering OVER, then 1 → RUN with full reload (prevents held button auto-restart).
- `start_btn` in RUN ignored. `collision` outside RUN ignored.

## Timing
- Reset values: state IDLE, `game_status`=0, `game_over`=0, `speed`=0, `ground_position`=0, `score`=0, `frame_tick`=0, `fresh` history register=0.
- `frame_tick` = `fresh` & ~`fresh_q`, registered: asserted the cycle after `fresh` is first sampled 1; exactly one cycle per rising edge regardless of `fresh` high time.
- Counters update on the clock edge ending the cycle in which `frame_tick`=1; visible one cycle later. Total `fresh` edge → `ground_position` change: 2 cycles.
- State transitions take effect the next edge; `game_status` is a registered decode of state.
- `rst` mid-game returns everything to reset values on the next edge, overriding all inputs.

## Configuration
- `SCROLL_PAUSE_EN` defined: adds state PAUSE. In RUN, `start_btn` rising edge → PAUSE (`game_status`=0, all counters frozen, ticks ignored, `collision` ignored); next `start_btn` rising edge → RUN without reload.
- Undefined: no PAUSE state; `start_btn` in RUN has no effect.

## Structure
- Shared package `dino_pkg`: state enum, `SPEED_W`=4, `POS_W`=6, `SCORE_W`=14 constants (also used by `Ground`).
- Sub-module `frame_tick_gen`: `fresh` synchroniser-free edge detector producing registered `frame_tick`.

## Test plan
- Reset, hold `start_btn`=0, toggle `fresh` 10 times → state IDLE, `speed`=0, `ground_position`=0, `score`=0.
- Start with INIT_SPEED=1, 70 frames → `ground_position`=6 (70 mod 64), `score`=70, `speed`=1.
- STEP_FRAMES=4, MAX_SPEED=3, run 20 frames → speed sequence 1,2,3 then held at 3; position equals running sum mod 64.
- `collision`=1 in same cycle as `frame_tick` → OVER, position/score unchanged from prior frame; `start_btn` held through → stays OVER; release then press → RUN with `score`=0, `speed`=INIT_SPEED.
- `fresh` held high 100 cycles → exactly one `frame_tick`; `rst` pulsed during RUN → all outputs reset next cycle.
- With `SCROLL_PAUSE_EN`: press in RUN → PAUSE, 5 frames produce no change; press again → RUN, advance resumes from frozen values.
